// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            byte producers, with per-requester packet lock.
//            Optional watchdog built when UART_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PAYLOAD_BITS   = 8,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic                            Tx_clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [PAYLOAD_BITS-1:0]         Tx_Data,
    output logic                            Enable_Tx,
    input  logic                            Tx_Line_busy,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic                            owner_valid,
    output logic                            timeout
);

    localparam int              OW       = $clog2(NUM_REQ);
    localparam logic [OW-1:0]   LAST_IDX = OW'(NUM_REQ - 1);
    localparam logic [OW-1:0]   ONE_IDX  = OW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OW-1:0]           last_grant_q, last_grant_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic                    owner_valid_q, owner_valid_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic                    enable_q, enable_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;

    logic                    sel_found;
    logic [OW-1:0]           sel_idx;
    logic [OW-1:0]           cand;
    logic [PAYLOAD_BITS-1:0] sel_data;
    logic [PAYLOAD_BITS-1:0] owner_data;
    logic                    tmo_hit;

    // Search upward from last_grant+1; wrap by compare so any NUM_REQ works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + ONE_IDX;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + ONE_IDX;
        end
    end

    assign sel_data   = req_data[sel_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign owner_data = req_data[owner_q*PAYLOAD_BITS +: PAYLOAD_BITS];

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        tx_data_d     = tx_data_q;
        enable_d      = enable_q;
        ack_d         = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    tx_data_d      = sel_data;
                    enable_d       = 1'b1;
                    ack_d[sel_idx] = 1'b1;
                    owner_d        = sel_idx;
                    last_grant_d   = sel_idx;
                    owner_valid_d  = 1'b1;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (tmo_hit) begin
                    enable_d      = 1'b0;
                    owner_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end else if (Tx_Line_busy) begin
                    enable_d = 1'b0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (tmo_hit) begin
                    enable_d      = 1'b0;
                    owner_valid_d = 1'b0;
                    state_d       = S_IDLE;
                end else if (!Tx_Line_busy) begin
                    // A locked owner with another byte ready keeps the line.
                    if (lock[owner_q] && req[owner_q]) begin
                        tx_data_d      = owner_data;
                        enable_d       = 1'b1;
                        ack_d[owner_q] = 1'b1;
                        state_d        = S_START;
                    end else begin
                        owner_valid_d = 1'b0;
                        state_d       = S_IDLE;
                    end
                end
            end
            default: begin
                enable_d      = 1'b0;
                owner_valid_d = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Tx_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= LAST_IDX;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            tx_data_q     <= '0;
            enable_q      <= 1'b0;
            ack_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            tx_data_q     <= tx_data_d;
            enable_q      <= enable_d;
            ack_q         <= ack_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q;

    assign tmo_hit = (state_q != S_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in the current START/SEND visit only.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge Tx_clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
    assign timeout        = 1'b0;
`endif

    assign ack         = ack_q;
    assign Tx_Data     = tx_data_q;
    assign Enable_Tx   = enable_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed scoreboard bench for uart_tx_arbiter with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  Tx_Data;
    logic        Enable_Tx;
    logic        busy;
    logic [1:0]  owner;
    logic        owner_valid;
    logic        timeout;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .PAYLOAD_BITS   (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Tx_clk       (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .req_data     (req_data),
        .ack          (ack),
        .Tx_Data      (Tx_Data),
        .Enable_Tx    (Enable_Tx),
        .Tx_Line_busy (busy),
        .owner        (owner),
        .owner_valid  (owner_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         acks_seen = 0;
    int         fall_cyc = -1000;

    logic [7:0] pdata[4][8];
    logic       plock[4][8];
    int         pn[4];
    int         pi[4];

    logic       model_en;
    int         mlen;
    int         mph;
    int         mcnt;
    logic       prev_en;
    logic       prev_busy;
    logic [3:0] prev_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic lk);
        pdata[i][pn[i]] = d;
        plock[i][pn[i]] = lk;
        pn[i]++;
    endtask

    task automatic advance(input int i);
        if (pi[i] < pn[i]) begin
            req_data[i*8 +: 8] = pdata[i][pi[i]];
            lock[i]            = plock[i][pi[i]];
            req[i]             = 1'b1;
            pi[i]++;
        end else begin
            req[i]  = 1'b0;
            lock[i] = 1'b0;
        end
    endtask

    task automatic expect_grant(input int i, input logic [7:0] d, input int gap);
        exp_t e;
        e.idx  = i;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    // One cycle: sample at negedge, check, react as producers, then UART model.
    task automatic step();
        exp_t       e;
        logic [3:0] oh;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (prev_en && prev_busy) chk("en_fall_after_busy", {31'd0, Enable_Tx}, 32'd0);
            if (prev_ack != 4'd0) chk("ack_width", {28'd0, ack}, 32'd0);
            if (ack != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {28'd0, ack}, 32'd0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.idx;
                    chk("ack_onehot", {28'd0, ack}, {28'd0, oh});
                    chk("tx_data", {24'd0, Tx_Data}, {24'd0, e.data});
                    chk("owner", {30'd0, owner}, e.idx);
                    chk("owner_valid", {31'd0, owner_valid}, 32'd1);
                    chk("enable_with_ack", {31'd0, Enable_Tx}, 32'd1);
                    if (e.gap >= 0) chk("busy_fall_to_grant", cyc - fall_cyc, e.gap);
                    acks_seen++;
                end
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) advance(i);
                end
            end
        end
        if (!model_en) begin
            busy = 1'b0;
            mph  = 0;
        end else begin
            case (mph)
                0: if (Enable_Tx) begin mph = 1; mcnt = 1; end
                1: if (mcnt == 0) begin busy = 1'b1; mcnt = mlen - 1; mph = 2; end
                   else mcnt--;
                default: if (mcnt == 0) begin busy = 1'b0; fall_cyc = cyc; mph = 0; end
                         else mcnt--;
            endcase
        end
        prev_en   = Enable_Tx;
        prev_busy = busy;
        prev_ack  = ack;
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int tgt;
        int k;
        tgt = acks_seen + n;
        k   = 0;
        while (acks_seen < tgt && k < budget) begin
            step();
            k++;
        end
        total++;
        assert (acks_seen >= tgt)
        else begin
            bad++;
            $error("FAIL %s: acks=%0d required=%0d", tag, acks_seen, tgt);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((owner_valid || busy || sb.size() != 0) && k < budget) begin
            step();
            k++;
        end
        total++;
        assert (!owner_valid && !busy && sb.size() == 0)
        else begin
            bad++;
            $error("FAIL %s: owner_valid=%0b busy=%0b pending=%0d required idle", tag,
                   owner_valid, busy, sb.size());
        end
    endtask

    initial begin
        int k;
        rst      = 1'b1;
        req      = 4'd0;
        lock     = 4'd0;
        req_data = 32'd0;
        busy     = 1'b0;
        model_en = 1'b0;
        mlen     = 100;
        mph      = 0;
        mcnt     = 0;
        prev_en  = 1'b0;
        prev_busy = 1'b0;
        prev_ack = 4'd0;
        for (int i = 0; i < 4; i++) begin
            pn[i] = 0;
            pi[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_enable", {31'd0, Enable_Tx}, 32'd0);
        chk("rst_txdata", {24'd0, Tx_Data}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_owner_valid", {31'd0, owner_valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rst      = 1'b0;
        model_en = 1'b1;

        // Single requester, long frame
        add_byte(1, 8'hA5, 1'b0);
        advance(1);
        expect_grant(1, 8'hA5, -1);
        wait_acks(1, 10, "single_grant");
        wait_idle(300, "single_idle");
        chk("single_end_enable", {31'd0, Enable_Tx}, 32'd0);
        chk("single_end_ov", {31'd0, owner_valid}, 32'd0);

        // Fairness: 0 and 2 continuous, 3 joins after two grants
        mlen = 8;
        add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b0); add_byte(0, 8'h03, 1'b0);
        add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h23, 1'b0);
        add_byte(3, 8'h3C, 1'b0);
        advance(0);
        advance(2);
        expect_grant(2, 8'h21, -1);
        expect_grant(0, 8'h01, 2);
        expect_grant(2, 8'h22, 2);
        expect_grant(3, 8'h3C, 2);
        expect_grant(0, 8'h02, 2);
        expect_grant(2, 8'h23, 2);
        expect_grant(0, 8'h03, 2);
        wait_acks(2, 60, "fair_first_two");
        advance(3);
        wait_acks(5, 150, "fair_rest");
        wait_idle(60, "fair_idle");

        // Locked burst from requester 1 while requester 0 waits
        add_byte(1, 8'h11, 1'b1); add_byte(1, 8'h22, 1'b1); add_byte(1, 8'h33, 1'b1);
        add_byte(0, 8'h0F, 1'b0);
        advance(1);
        expect_grant(1, 8'h11, -1);
        expect_grant(1, 8'h22, 1);
        expect_grant(1, 8'h33, 1);
        expect_grant(0, 8'h0F, 2);
        wait_acks(1, 10, "lock_first");
        advance(0);
        wait_acks(3, 100, "lock_rest");
        wait_idle(60, "lock_idle");

        // Reset while the line is busy, then pointer restart
        add_byte(2, 8'h77, 1'b0);
        advance(2);
        expect_grant(2, 8'h77, -1);
        wait_acks(1, 10, "rst_pre_grant");
        k = 0;
        while (!(busy && !Enable_Tx) && k < 40) begin
            step();
            k++;
        end
        total++;
        assert (busy && !Enable_Tx)
        else begin
            bad++;
            $error("FAIL rst_reach_send: busy=%0b enable=%0b required busy=1 enable=0",
                   busy, Enable_Tx);
        end
        rst = 1'b1;
        #1;
        chk("midrst_enable", {31'd0, Enable_Tx}, 32'd0);
        chk("midrst_ack", {28'd0, ack}, 32'd0);
        chk("midrst_ov", {31'd0, owner_valid}, 32'd0);
        chk("midrst_owner", {30'd0, owner}, 32'd0);
        chk("midrst_txdata", {24'd0, Tx_Data}, 32'd0);
        req      = 4'd0;
        lock     = 4'd0;
        model_en = 1'b0;
        step();
        step();
        rst      = 1'b0;
        model_en = 1'b1;
        add_byte(2, 8'h5A, 1'b0);
        add_byte(3, 8'h5B, 1'b0);
        advance(2);
        advance(3);
        expect_grant(2, 8'h5A, -1);
        expect_grant(3, 8'h5B, 2);
        wait_acks(2, 60, "post_rst_grants");
        wait_idle(60, "post_rst_idle");

        // Line never goes busy after a grant to requester 1
        model_en = 1'b0;
        step();
        add_byte(1, 8'h99, 1'b0);
        add_byte(2, 8'h2A, 1'b0);
        advance(1);
        advance(2);
        expect_grant(1, 8'h99, -1);
        expect_grant(2, 8'h2A, -1);
        wait_acks(1, 10, "tmo_grant");
        for (int j = 1; j <= 15; j++) step();
        chk("tmo_pre_enable", {31'd0, Enable_Tx}, 32'd1);
        chk("tmo_pre_pulse", {31'd0, timeout}, 32'd0);
        step();
`ifdef UART_ARB_TIMEOUT_EN
        chk("tmo_pulse", {31'd0, timeout}, 32'd1);
        chk("tmo_enable", {31'd0, Enable_Tx}, 32'd0);
        chk("tmo_ov", {31'd0, owner_valid}, 32'd0);
        model_en = 1'b1;
        wait_acks(1, 10, "tmo_next_grant");
        chk("tmo_pulse_width", {31'd0, timeout}, 32'd0);
`else
        chk("notmo_pulse", {31'd0, timeout}, 32'd0);
        chk("notmo_enable", {31'd0, Enable_Tx}, 32'd1);
        repeat (24) step();
        chk("notmo_late_pulse", {31'd0, timeout}, 32'd0);
        chk("notmo_late_enable", {31'd0, Enable_Tx}, 32'd1);
        chk("notmo_late_ov", {31'd0, owner_valid}, 32'd1);
        model_en = 1'b1;
        wait_acks(1, 40, "notmo_next_grant");
`endif
        wait_idle(60, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
